sd_loop_filter_param: RTL

//  Parametrised 1-bit sigma-delta loop filter: a STAGES-deep cascade of feedback integrators plus a 1-bit quantiser.

---
 rtl/sd_loop_filter_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_loop_filter_param.sv
// Parametrised 1-bit sigma-delta loop filter: cascaded feedback integrators, 1-bit quantiser,
// double-buffered coefficients, optional state saturation and an instability watchdog.
module sd_loop_filter_param #(
  parameter int WIDTH          = 32,
  parameter int STAGES         = 4,
  parameter int SHIFT          = 7,
  parameter int SATURATE       = 1,
  parameter int IDLE_LIMIT     = 1024,
  parameter int RECOVER_CYCLES = 16,
  parameter int AW             = $clog2(2*STAGES+1)
) (
  input  logic                    filter_clock,
  input  logic                    reset,
  input  logic                    filter_en,
  input  logic                    mainIn,
  output logic                    mainOut,
  input  logic                    coef_wr,
  input  logic [AW-1:0]           coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  input  logic                    coef_commit,
  output logic                    commit_pend,
  input  logic                    sat_clr,
  output logic                    sat_flag,
  output logic                    unstable,
  output logic [7:0]              recover_cnt
);

  localparam int NCOEF  = 2*STAGES + 1;
  localparam int EW     = WIDTH + 2;
  localparam int IDLE_W = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;
  localparam int REC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [REC_W-1:0]  REC_TOP  = REC_W'(RECOVER_CYCLES - 1);

  typedef logic signed [EW-1:0] ext_t;
  typedef enum logic {ST_RUN, ST_RECOVER} state_t;

  localparam ext_t MAXV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam ext_t MINV = {3'b111, {(WIDTH-1){1'b0}}};

  function automatic ext_t ext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Narrow a wide result back to WIDTH: clamp when saturating, otherwise keep the low bits.
  function automatic logic signed [WIDTH-1:0] narrow(input ext_t v);
    if ((SATURATE != 0) && (v > MAXV)) return MAXV[WIDTH-1:0];
    else if ((SATURATE != 0) && (v < MINV)) return MINV[WIDTH-1:0];
    else return v[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] coef_eff [NCOEF];
  logic signed [WIDTH-1:0] d_reg    [STAGES];
  logic signed [WIDTH-1:0] d_next   [STAGES];
  logic [STAGES-1:0]       d_clamp;
  logic signed [WIDTH-1:0] sd_reg, sd_next;
  logic                    sd_clamp;

  ext_t ff_term   [STAGES+1];
  ext_t fb_term   [STAGES];
  ext_t stage_sum [STAGES];
  ext_t d_wide    [STAGES];
  ext_t x_wide, q_wide, sd_wide;

  logic                y;
  state_t              state_reg, state_next;
  logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [REC_W-1:0]    rec_cnt_reg, rec_cnt_next;
  logic [7:0]          recover_cnt_reg, recover_cnt_next;
  logic                prev_out_reg, prev_out_next;
  logic                commit_pend_reg, commit_pend_next;
  logic                sat_flag_reg, sat_flag_next;
  logic                commit_apply, run_update, zero_state, sat_set;

  assign y = ~sd_reg[WIDTH-1];

  genvar gi;
  generate
    // Each coefficient has a shadow copy written by the host and an active copy used by the loop.
    for (gi = 0; gi < NCOEF; gi++) begin : g_coef
      localparam logic [AW-1:0] ADDR = AW'(gi);
      logic signed [WIDTH-1:0] shadow_reg, active_reg;

      always_ff @(posedge filter_clock or posedge reset) begin
        if (reset) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (coef_wr && (coef_addr == ADDR)) shadow_reg <= coef_data;
          if (commit_apply) active_reg <= shadow_reg;
        end
      end

      // The commit cycle itself already runs on the new set.
      assign coef_eff[gi] = commit_apply ? shadow_reg : active_reg;
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign ff_term[gi] = mainIn ? ext(coef_eff[gi]) : -ext(coef_eff[gi]);
      assign fb_term[gi] = y ? ext(coef_eff[STAGES+1+gi]) : -ext(coef_eff[STAGES+1+gi]);
      if (gi == 0) begin : g_first
        assign stage_sum[gi] = ff_term[gi] - fb_term[gi];
      end else begin : g_chain
        assign stage_sum[gi] = ff_term[gi] - fb_term[gi] + (ext(d_reg[gi-1]) >>> SHIFT);
      end
      assign d_wide[gi]  = stage_sum[gi] - ext(d_reg[gi]);
      assign d_clamp[gi] = (SATURATE != 0) && ((d_wide[gi] > MAXV) || (d_wide[gi] < MINV));
      assign d_next[gi]  = narrow(d_wide[gi]);
    end
  endgenerate

  assign ff_term[STAGES] = mainIn ? ext(coef_eff[STAGES]) : -ext(coef_eff[STAGES]);
  assign x_wide   = ff_term[STAGES] + (ext(d_reg[STAGES-1]) >>> SHIFT);
  assign q_wide   = y ? MAXV : MINV;
  assign sd_wide  = x_wide - q_wide - ext(sd_reg);
  assign sd_clamp = (SATURATE != 0) && ((sd_wide > MAXV) || (sd_wide < MINV));
  assign sd_next  = narrow(sd_wide);

  always_comb begin
    state_next       = state_reg;
    idle_cnt_next    = idle_cnt_reg;
    rec_cnt_next     = rec_cnt_reg;
    recover_cnt_next = recover_cnt_reg;
    prev_out_next    = prev_out_reg;
    commit_apply     = 1'b0;
    run_update       = 1'b0;
    zero_state       = 1'b0;
    commit_pend_next = commit_pend_reg | coef_commit;
    if (filter_en) begin
      prev_out_next = y;
      case (state_reg)
        ST_RUN: begin
          commit_apply = commit_pend_reg;
          if (y == prev_out_reg) begin
            if (idle_cnt_reg == IDLE_TOP) begin
              state_next       = ST_RECOVER;
              zero_state       = 1'b1;
              rec_cnt_next     = '0;
              recover_cnt_next = (recover_cnt_reg == 8'hFF) ? 8'hFF : recover_cnt_reg + 8'd1;
            end else begin
              idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
              run_update    = 1'b1;
            end
          end else begin
            idle_cnt_next = '0;
            run_update    = 1'b1;
          end
        end
        ST_RECOVER: begin
          zero_state = 1'b1;
          if (rec_cnt_reg == REC_TOP) begin
            state_next    = ST_RUN;
            idle_cnt_next = '0;
          end else begin
            rec_cnt_next = rec_cnt_reg + REC_W'(1);
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
    if (commit_apply) commit_pend_next = 1'b0;
  end

  // A fresh clamp outranks a clear requested in the same cycle.
  assign sat_set       = run_update && ((|d_clamp) || sd_clamp);
  assign sat_flag_next = sat_set ? 1'b1 : (sat_clr ? 1'b0 : sat_flag_reg);

  always_ff @(posedge filter_clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) d_reg[k] <= '0;
      sd_reg <= '0;
    end else if (zero_state) begin
      for (int k = 0; k < STAGES; k++) d_reg[k] <= '0;
      sd_reg <= '0;
    end else if (run_update) begin
      for (int k = 0; k < STAGES; k++) d_reg[k] <= d_next[k];
      sd_reg <= sd_next;
    end
  end

  always_ff @(posedge filter_clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      idle_cnt_reg    <= '0;
      rec_cnt_reg     <= '0;
      recover_cnt_reg <= '0;
      prev_out_reg    <= 1'b1;
      commit_pend_reg <= 1'b0;
      sat_flag_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idle_cnt_reg    <= idle_cnt_next;
      rec_cnt_reg     <= rec_cnt_next;
      recover_cnt_reg <= recover_cnt_next;
      prev_out_reg    <= prev_out_next;
      commit_pend_reg <= commit_pend_next;
      sat_flag_reg    <= sat_flag_next;
    end
  end

  assign mainOut     = y;
  assign commit_pend = commit_pend_reg;
  assign sat_flag    = sat_flag_reg;
  assign unstable    = (state_reg == ST_RECOVER);
  assign recover_cnt = recover_cnt_reg;

endmodule
